// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM encoding and digit-count helpers for the multi-cycle subtractor
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Guarded against a zero digit so elaboration reaches the parameter check.
    function automatic int calc_num(input int width, input int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    function automatic int calc_cnt_w(input int num);
        return (num <= 1) ? 1 : $clog2(num);
    endfunction

endpackage

// File: rtl/multi_cycle_subtractor_if.sv
// rtl/multi_cycle_subtractor_if.sv - operand/result handshake bundle for the multi-cycle subtractor
interface multi_cycle_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow, zero
    );
endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell of the digit ripple chain
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_diff,
    output logic o_borrow
);
    assign o_diff   = i_a ^ i_b ^ i_cin;
    assign o_borrow = (~i_a & i_b) | (~(i_a ^ i_b) & i_cin);
endmodule

// File: rtl/multi_cycle_subtractor.sv
// rtl/multi_cycle_subtractor.sv - digit-serial subtractor, DIGIT bits per cycle, LSB digit first
module multi_cycle_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_cycle_subtractor_if.slave   bus
);
    localparam int NUM   = calc_num(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NUM);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("multi_cycle_subtractor: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_brun;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_zero;

    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT-1:0]   w_dig_diff;
    logic [DIGIT:0]     w_chain;
    logic [WIDTH-1:0]   w_diff_nxt;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(NUM - 1));

    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int k = 0; k < NUM; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_dig = r_a[k*DIGIT +: DIGIT];
                w_b_dig = r_b[k*DIGIT +: DIGIT];
            end
        end
    end

    assign w_chain[0] = r_brun;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_chain
            full_subtractor u_fs (
                .i_a      (w_a_dig[gi]),
                .i_b      (w_b_dig[gi]),
                .i_cin    (w_chain[gi]),
                .o_diff   (w_dig_diff[gi]),
                .o_borrow (w_chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        w_diff_nxt = r_diff;
        for (int k = 0; k < NUM; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_diff_nxt[k*DIGIT +: DIGIT] = w_dig_diff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_brun   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_brun <= bus.bin;
                        r_cnt  <= '0;
                        r_diff <= '0;
                    end
                end
                ST_CALC: begin
                    r_diff <= w_diff_nxt;
                    r_brun <= w_chain[DIGIT];
                    r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_borrow <= w_chain[DIGIT];
                        r_zero   <= (w_diff_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Results stay frozen through DONE because only CALC writes them.
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.zero      = r_zero;

endmodule

// File: doc/multi_cycle_subtractor.md
MULTI_CYCLE_SUBTRACTOR -- requirements
Module: multi_cycle_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per compute cycle.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  minuend.
REQ-009 b  input  WIDTH  subtrahend.
REQ-010 bin  input  1  borrow-in.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
REQ-014 borrow  output  1  borrow-out; 1 when a < b + bin (unsigned).
REQ-015 zero  output  1  1 when diff == 0.

Function
REQ-016 SHALL reject elaboration unless WIDTH >= 1, DIGIT >= 1 and WIDTH % DIGIT == 0; NUM = WIDTH/DIGIT.
REQ-017 SHALL implement FSM states IDLE, CALC, DONE.
REQ-018 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-019 IDLE: on in_valid & in_ready, SHALL latch a, b and bin, clear digit counter, clear result register, and move to CALC; otherwise stay in IDLE.
REQ-020 CALC: each cycle SHALL compute digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1, LSB digit first) using the running borrow, write those diff bits, update the running borrow, and increment k.
REQ-021 SHALL initialise the running borrow from the latched bin for digit 0.
REQ-022 After digit NUM-1, SHALL enter DONE; out_valid SHALL assert exactly NUM cycles after the accepting edge.
REQ-023 DONE: diff, borrow and zero SHALL be held stable while out_valid & !out_ready; on out_ready, SHALL return to IDLE on the next edge.
REQ-024 SHALL ignore in_valid, a, b and bin outside IDLE; no accept SHALL occur in the cycle DONE is left, so the minimum initiation interval is NUM+2 cycles.
REQ-025 diff, borrow and zero SHALL be registered outputs with no combinational path from inputs.
REQ-026 Values of diff, borrow and zero outside DONE are don't-care, but SHALL NOT be X after reset.
REQ-027 Results SHALL be independent of operand input changes after acceptance.
REQ-028 Boundary: with a == b and bin = 1, result SHALL be diff = all-ones, borrow = 1; with a = 0, b = all-ones and bin = 1, result SHALL be diff = 0, borrow = 1, zero = 1.

Reset
REQ-029 On rst: state IDLE, digit counter 0, in_ready 1, out_valid 0, diff 0, borrow 0, zero 0.
REQ-030 rst asserted in CALC or DONE SHALL abort the operation and discard the result; no out_valid SHALL follow for it.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-032 SHALL place the FSM state encoding and the NUM/counter-width derivation in a shared package (arith_pkg).
REQ-033 SHALL build the per-cycle datapath from a DIGIT-wide ripple chain of one sub-module, full_subtractor (a, b, cin -> diff, borrow), instanced DIGIT times via generate.
REQ-034 The digit counter width SHALL be clog2(NUM), minimum 1.

Verification
REQ-035 WIDTH=8, DIGIT=4: a=0x35, b=0x12, bin=0 -> out_valid 2 cycles after accept, diff=0x23, borrow=0, zero=0.
REQ-036 WIDTH=8, DIGIT=4: a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1; a=0x80, b=0x7F, bin=1 -> diff=0x00, borrow=0, zero=1.
REQ-037 Backpressure: out_ready held 0 for 5 cycles in DONE, with in_valid=1 and changing operands -> result stable, in_ready=0, single result delivered on out_ready.
REQ-038 Reset mid-CALC (WIDTH=16, DIGIT=4, rst at cycle 2 of 4) -> next cycle IDLE, in_ready=1, out_valid=0; following op a=0x1234, b=0x0234 -> diff=0x1000.
REQ-039 WIDTH=4, DIGIT=1 exhaustive over a, b, bin (512 cases) vs model (a-b-bin) -> diff, borrow, zero match; latency 4 every case.
REQ-040 Boundary: WIDTH=8, DIGIT=8 (NUM=1) a=0x00, b=0xFF, bin=1 -> latency 1, diff=0x00, borrow=1, zero=1.
